address_sequencer: RTL and testbench

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

---
 rtl/address_sequencer.sv | 138 +++++++++++++
 tb/tb_address_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/address_sequencer.sv
// address_sequencer: presents a sequence of {column,row} addresses to a
// downstream store using a newAddress/storageReady handshake.
// Linear mode walks base, base+stride, ... with silent wrap-around.
// Defining ADDRSEQ_TABLE_EN compiles in a writable address table and table
// mode; without it mode is treated as 0 and the table ports are ignored.
module address_sequencer #(
  parameter int COLINDEXBITS = 4,
  parameter int ROWINDEXBITS = 4,
  parameter int TABLEDEPTH   = 32,
  localparam int ADDRBITS    = COLINDEXBITS + ROWINDEXBITS,
  localparam int TBLBITS     = $clog2(TABLEDEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [ADDRBITS-1:0] base,
  input  logic [ADDRBITS-1:0] stride,
  input  logic [ADDRBITS:0]   length,
  input  logic                continuous,
  input  logic                storageReady,
  output logic [ADDRBITS-1:0] address,
  output logic                newAddress,
  output logic                busy,
  output logic                done,
  input  logic                tblWrite,
  input  logic [TBLBITS-1:0]  tblWrAddr,
  input  logic [ADDRBITS-1:0] tblWrData
);

  localparam logic [ADDRBITS:0] LEN_ONE = (ADDRBITS+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [ADDRBITS-1:0] cfg_base;
  logic [ADDRBITS-1:0] cfg_stride;
  logic [ADDRBITS:0]   cfg_length;
  logic                cfg_continuous;
  logic [ADDRBITS:0]   index;
  logic [ADDRBITS-1:0] lin_addr;
  logic [ADDRBITS-1:0] element;
  logic                accept;
  logic                last;

  assign busy       = (state == RUN);
  assign newAddress = busy;
  assign done       = (state == DONE);
  assign address    = busy ? element : '0;
  assign accept     = newAddress && storageReady;
  assign last       = (index == cfg_length - LEN_ONE);

  // State register; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: stop beats a simultaneous acceptance, a zero-length
  // start goes straight to DONE, continuous passes never leave RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        if (stop) next_state = IDLE;
        else if (accept && last && !cfg_continuous) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Configuration capture at start and element advance on each acceptance;
  // the linear address is accumulated so no multiplier is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_base       <= '0;
      cfg_stride     <= '0;
      cfg_length     <= '0;
      cfg_continuous <= 1'b0;
      index          <= '0;
      lin_addr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_base       <= base;
            cfg_stride     <= stride;
            cfg_length     <= length;
            cfg_continuous <= continuous;
            index          <= '0;
            lin_addr       <= base;
          end
        end
        RUN: begin
          if (!stop && accept) begin
            if (last) begin
              index    <= '0;
              lin_addr <= cfg_base;
            end else begin
              index    <= index + LEN_ONE;
              lin_addr <= lin_addr + cfg_stride;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDRSEQ_TABLE_EN
  logic [ADDRBITS-1:0] table_mem [TABLEDEPTH];
  logic                cfg_mode;

  // Table writes land only while no sequence is running; contents survive reset.
  always_ff @(posedge clock) begin
    if (tblWrite && state != RUN) table_mem[tblWrAddr] <= tblWrData;
  end

  // Mode is captured together with the rest of the configuration.
  always_ff @(posedge clock) begin
    if (reset)                     cfg_mode <= 1'b0;
    else if (state == IDLE && start) cfg_mode <= mode;
  end

  assign element = cfg_mode ? table_mem[index[TBLBITS-1:0]] : lin_addr;
`else
  logic unused_table_ports;
  assign unused_table_ports = ^{mode, tblWrite, tblWrAddr, tblWrData};
  assign element = lin_addr;
`endif

endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: directed scenarios plus randomized traffic, all
// compared every cycle against a behavioural model of the sequencer.
// Builds with or without ADDRSEQ_TABLE_EN.
module tb_address_sequencer;
  localparam int AB  = 8;
  localparam int TD  = 32;
  localparam int TBB = 5;

  logic          clock = 1'b0;
  logic          reset, start, stop, mode, continuous, storageReady, tblWrite;
  logic [AB-1:0] base, stride, tblWrData;
  logic [AB:0]   length;
  logic [TBB-1:0] tblWrAddr;
  logic [AB-1:0] address;
  logic          newAddress, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit compare_en = 1'b0;
  int cap_addr[$];
  int cap_cyc[$];
  int exp_q[$];
  int done_cnt = 0;
  int nad_cnt  = 0;

  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  bit            m_mode   = 1'b0;
  bit            m_cont   = 1'b0;
  int            m_idx    = 0;
  int            m_len    = 0;
  logic [AB-1:0] m_base   = '0;
  logic [AB-1:0] m_stride = '0;
`ifdef ADDRSEQ_TABLE_EN
  logic [AB-1:0] m_tbl [TD];
`endif
  logic [AB-1:0] exp_addr;

  address_sequencer #(.COLINDEXBITS(4), .ROWINDEXBITS(4), .TABLEDEPTH(TD)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .base(base), .stride(stride), .length(length), .continuous(continuous),
    .storageReady(storageReady), .address(address), .newAddress(newAddress),
    .busy(busy), .done(done), .tblWrite(tblWrite), .tblWrAddr(tblWrAddr),
    .tblWrData(tblWrData)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Element i of the current pass, straight from the addressing rules.
  function automatic logic [AB-1:0] m_elem(input int i);
    logic [31:0] t;
`ifdef ADDRSEQ_TABLE_EN
    if (m_mode) return m_tbl[i % TD];
`endif
    t = 32'(m_base) + 32'(i) * 32'(m_stride);
    return t[AB-1:0];
  endfunction

  // Behavioural model advanced with the inputs the DUT sees at each edge.
  always @(posedge clock) begin
    cyc++;
`ifdef ADDRSEQ_TABLE_EN
    if (tblWrite && !m_active) m_tbl[tblWrAddr] = tblWrData;
`endif
    if (reset) begin
      m_active = 1'b0; m_done = 1'b0; m_idx = 0; m_len = 0;
      m_base = '0; m_stride = '0; m_cont = 1'b0; m_mode = 1'b0;
    end else if (m_active) begin
      if (stop) m_active = 1'b0;
      else if (storageReady) begin
        if (m_idx == m_len - 1) begin
          m_idx = 0;
          if (!m_cont) begin m_active = 1'b0; m_done = 1'b1; end
        end else m_idx++;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_base = base; m_stride = stride; m_len = int'(length); m_cont = continuous;
`ifdef ADDRSEQ_TABLE_EN
      m_mode = mode;
`else
      m_mode = 1'b0;
`endif
      m_idx = 0;
      if (m_len == 0) m_done = 1'b1;
      else m_active = 1'b1;
    end
  end

  // Per-cycle comparison against the model, plus capture of accepted addresses.
  always @(negedge clock) begin
    if (compare_en) begin
      exp_addr = m_active ? m_elem(m_idx) : '0;
      check_output("address", 32'(address), 32'(exp_addr));
      check_output("newAddress", 32'(newAddress), 32'(m_active));
      check_output("busy", 32'(busy), 32'(m_active));
      check_output("done", 32'(done), 32'(m_done));
      if (newAddress && storageReady && !stop && !reset) begin
        cap_addr.push_back(int'(address));
        cap_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (newAddress) nad_cnt++;
    end
  end

  task automatic apply_stimulus(input bit m, input int b, input int s, input int l, input bit c);
    mode = m; base = AB'(b); stride = AB'(s); length = (AB+1)'(l); continuous = c;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done) return;
      step;
    end
    check_output({name, " done timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_caps(input string name, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      step;
      if (cap_addr.size() >= n) return;
    end
    check_output({name, " capture timeout"}, 32'(cap_addr.size()), 32'(n));
  endtask

  task automatic check_caps(input string name);
    check_output({name, " count"}, 32'(cap_addr.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < cap_addr.size()) check_output(name, 32'(cap_addr[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_caps;
    cap_addr.delete();
    cap_cyc.delete();
  endtask

  initial begin
    int d0, n0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; continuous = 1'b0;
    storageReady = 1'b0; tblWrite = 1'b0; base = '0; stride = '0; length = '0;
    tblWrAddr = '0; tblWrData = '0;
    step; step;
    reset = 1'b0;
    compare_en = 1'b1;
    check_output("reset address", 32'(address), 32'd0);
    check_output("reset newAddress", 32'(newAddress), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);

`ifdef ADDRSEQ_TABLE_EN
    for (int i = 0; i < TD; i++) begin
      tblWrAddr = TBB'(i);
      tblWrData = (i == 0) ? 8'h84 : (i == 1) ? 8'h83 : (i == 2) ? 8'h88 : AB'($urandom);
      tblWrite = 1'b1;
      step;
    end
    tblWrite = 1'b0;
`endif

    // Linear, unit stride, always ready.
    $display("[TB] linear stride 1");
    clear_caps(); storageReady = 1'b1; d0 = done_cnt;
    apply_stimulus(1'b0, 'h10, 1, 4, 1'b0);
    wait_done("lin1", 20);
    step;
    exp_q = '{'h10, 'h11, 'h12, 'h13};
    check_caps("lin1");
    for (int i = 1; i < cap_cyc.size(); i++)
      check_output("lin1 spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
    check_output("lin1 done pulses", 32'(done_cnt - d0), 32'd1);

    // Linear with wrap-around and a toggling ready.
    $display("[TB] linear wrap, ready toggling");
    clear_caps(); storageReady = 1'b1;
    apply_stimulus(1'b0, 'hFE, 3, 3, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      step;
      storageReady = ~storageReady;
    end
    check_output("wrap done seen", 32'(done), 32'd1);
    exp_q = '{'hFE, 'h01, 'h04};
    check_caps("wrap");
    for (int i = 1; i < cap_cyc.size(); i++)
      check_output("wrap hold", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd2);
    step;

    // Zero length: done pulse, never a valid address.
    $display("[TB] zero length");
    storageReady = 1'b1; n0 = nad_cnt;
    apply_stimulus(1'b0, 'h33, 1, 0, 1'b0);
    check_output("len0 done", 32'(done), 32'd1);
    step;
    check_output("len0 done cleared", 32'(done), 32'd0);
    check_output("len0 newAddress count", 32'(nad_cnt - n0), 32'd0);

    // Continuous linear pass, then stop.
    $display("[TB] continuous linear");
    clear_caps(); storageReady = 1'b1; d0 = done_cnt;
    apply_stimulus(1'b0, 5, 1, 2, 1'b1);
    wait_caps("cont", 5, 20);
    stop = 1'b1; step; stop = 1'b0;
    check_output("cont stop newAddress", 32'(newAddress), 32'd0);
    exp_q = '{5, 6, 5, 6, 5};
    check_caps("cont");
    check_output("cont no done", 32'(done_cnt - d0), 32'd0);

`ifdef ADDRSEQ_TABLE_EN
    $display("[TB] table continuous");
    clear_caps(); storageReady = 1'b1; d0 = done_cnt;
    apply_stimulus(1'b1, 0, 0, 3, 1'b1);
    wait_caps("tbl", 7, 30);
    stop = 1'b1; step; stop = 1'b0;
    check_output("tbl stop newAddress", 32'(newAddress), 32'd0);
    check_output("tbl stop done", 32'(done), 32'd0);
    exp_q = '{'h84, 'h83, 'h88, 'h84, 'h83, 'h88, 'h84};
    check_caps("tbl");
    check_output("tbl no done", 32'(done_cnt - d0), 32'd0);

    $display("[TB] table write while busy");
    storageReady = 1'b0;
    apply_stimulus(1'b1, 0, 0, 3, 1'b1);
    check_output("busy during write", 32'(busy), 32'd1);
    tblWrAddr = TBB'(1); tblWrData = 8'h55; tblWrite = 1'b1;
    step;
    tblWrite = 1'b0; stop = 1'b1; step; stop = 1'b0;
    clear_caps(); storageReady = 1'b1;
    apply_stimulus(1'b1, 0, 0, 3, 1'b0);
    wait_done("tblw", 20);
    exp_q = '{'h84, 'h83, 'h88};
    check_caps("tbl busy write");
    step;
`else
    $display("[TB] mode=1 without table");
    clear_caps(); storageReady = 1'b1;
    apply_stimulus(1'b1, 'h20, 2, 3, 1'b0);
    wait_done("nomode", 20);
    exp_q = '{'h20, 'h22, 'h24};
    check_caps("mode ignored");
    step;
`endif

    // Reset while presenting element 2.
    $display("[TB] reset mid-sequence");
    clear_caps(); storageReady = 1'b1;
    apply_stimulus(1'b0, 'h40, 1, 8, 1'b0);
    wait_caps("rst", 2, 20);
    check_output("rst elem2 address", 32'(address), 32'h42);
    check_output("rst elem2 valid", 32'(newAddress), 32'd1);
    reset = 1'b1; storageReady = 1'b0;
    step;
    reset = 1'b0;
    check_output("rst address", 32'(address), 32'd0);
    check_output("rst newAddress", 32'(newAddress), 32'd0);
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
`ifdef ADDRSEQ_TABLE_EN
    clear_caps(); storageReady = 1'b1;
    apply_stimulus(1'b1, 0, 0, 3, 1'b0);
    wait_done("tblkeep", 20);
    exp_q = '{'h84, 'h83, 'h88};
    check_caps("table kept");
    step;
`endif

    // Randomized traffic checked cycle by cycle against the model.
    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++) begin
      storageReady = ($urandom_range(0, 3) != 0);
      start        = ($urandom_range(0, 7) == 0);
      stop         = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      mode         = ($urandom_range(0, 1) == 1);
      continuous   = ($urandom_range(0, 3) == 0);
      base         = AB'($urandom);
      stride       = AB'($urandom);
      length       = (AB+1)'($urandom_range(0, 6));
      tblWrite     = ($urandom_range(0, 9) == 0);
      tblWrAddr    = TBB'($urandom);
      tblWrData    = AB'($urandom);
      step;
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0; tblWrite = 1'b0;
    step; step; step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
